// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding and control FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/opcode issue bus and result/flag return bus of the sequential ALU.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the operation side and the result side.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       OPCODE;
    logic [WIDTH-1:0] OP1;
    logic [WIDTH-1:0] OP2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             flag_n;

    // Issue logic / writeback side.
    modport master (
        output in_valid, OPCODE, OP1, OP2, out_ready,
        input  in_ready, out_valid, res_lo, res_hi, flag_z, flag_c, flag_v, flag_n
    );

    // ALU side.
    modport slave (
        input  in_valid, OPCODE, OP1, OP2, out_ready,
        output in_ready, out_valid, res_lo, res_hi, flag_z, flag_c, flag_v, flag_n
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier, one partial product per cycle, 2*WIDTH product.
// Latency: WIDTH iterations after start; done flags the cycle of the final iteration.
// Backpressure: none; start while busy restarts, the owner keeps it idle meanwhile.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_nxt;

    // Add the multiplicand into the upper half when the current multiplier bit is set,
    // then shift the whole accumulator right by one (carry moves into the top bit).
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_nxt = {sum, acc[WIDTH-1:1]};
    end

    // product is the value the accumulator takes at the end of this cycle, so the
    // owner can capture the finished product on the same edge as the last iteration.
    assign busy    = (cnt != '0);
    assign done    = (cnt == CW'(1));
    assign product = acc_nxt;

    // Load operands on start, otherwise iterate while the counter is non-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= mcand_in;
            mplier <= mplier_in;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
        end else if (busy) begin
            acc    <= acc_nxt;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: add/sub/logic/shift in one cycle, unsigned multiply via shift-add.
// Latency: 1 cycle from accept to out_valid; WIDTH+1 cycles for MUL.
// Backpressure: result held while out_ready=0; in_ready follows out_ready while a result is pending.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    state_e             state;
    opcode_e            op;
    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [SHW-1:0]     amt;
    logic [WIDTH:0]     wide;
    logic [WIDTH-1:0]   alu_lo;
    logic               alu_c;
    logic               alu_v;

    assign op        = opcode_e'(bus.OPCODE);
    assign amt       = bus.OP2[SHW-1:0];
    // A pending result frees the slot in the same cycle the consumer takes it.
    assign bus.in_ready = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
    assign accept    = bus.in_valid && bus.in_ready;
    assign mul_start = accept && (op == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (mul_start),
        .mcand_in  (bus.OP1),
        .mplier_in (bus.OP2),
        .busy      (mul_busy),
        .done      (mul_done),
        .product   (mul_prod)
    );

    // Single-cycle datapath: result, carry/borrow/shift-out and signed overflow.
    always_comb begin
        wide   = '0;
        alu_lo = '0;
        alu_c  = 1'b0;
        alu_v  = 1'b0;
        unique case (op)
            OP_ADD: begin
                wide   = {1'b0, bus.OP1} + {1'b0, bus.OP2};
                alu_lo = wide[WIDTH-1:0];
                alu_c  = wide[WIDTH];
                alu_v  = (bus.OP1[WIDTH-1] == bus.OP2[WIDTH-1]) && (alu_lo[WIDTH-1] != bus.OP1[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is set exactly when OP1 < OP2.
                wide   = {1'b0, bus.OP1} - {1'b0, bus.OP2};
                alu_lo = wide[WIDTH-1:0];
                alu_c  = wide[WIDTH];
                alu_v  = (bus.OP1[WIDTH-1] != bus.OP2[WIDTH-1]) && (alu_lo[WIDTH-1] != bus.OP1[WIDTH-1]);
            end
            OP_AND: alu_lo = bus.OP1 & bus.OP2;
            OP_OR:  alu_lo = bus.OP1 | bus.OP2;
            OP_XOR: alu_lo = bus.OP1 ^ bus.OP2;
            OP_SHL: begin
                // The extra top bit catches the last bit shifted out (0 for amount 0).
                wide   = {1'b0, bus.OP1} << amt;
                alu_lo = wide[WIDTH-1:0];
                alu_c  = wide[WIDTH];
            end
            OP_SHR: begin
                wide   = {bus.OP1, 1'b0} >> amt;
                alu_lo = wide[WIDTH:1];
                alu_c  = wide[0];
            end
            default: ;
        endcase
    end

    // Control FSM with registered result, flags and out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus.out_valid <= 1'b0;
            bus.res_lo    <= '0;
            bus.res_hi    <= '0;
            bus.flag_z    <= 1'b0;
            bus.flag_c    <= 1'b0;
            bus.flag_v    <= 1'b0;
            bus.flag_n    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state         <= ST_MUL;
                            bus.out_valid <= 1'b0;
                        end else begin
                            state         <= ST_DONE;
                            bus.out_valid <= 1'b1;
                            bus.res_lo    <= alu_lo;
                            bus.res_hi    <= '0;
                            bus.flag_z    <= (alu_lo == '0);
                            bus.flag_c    <= alu_c;
                            bus.flag_v    <= alu_v;
                            bus.flag_n    <= alu_lo[WIDTH-1];
                        end
                    end else if ((state == ST_DONE) && bus.out_ready) begin
                        state         <= ST_IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state         <= ST_DONE;
                        bus.out_valid <= 1'b1;
                        bus.res_lo    <= mul_prod[WIDTH-1:0];
                        bus.res_hi    <= mul_prod[2*WIDTH-1:WIDTH];
                        bus.flag_z    <= (mul_prod == '0);
                        bus.flag_c    <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
                        bus.flag_v    <= 1'b0;
                        bus.flag_n    <= mul_prod[2*WIDTH-1];
                    end else if (!mul_busy) begin
                        // Multiplier lost its operation without finishing; do not hang.
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8 with a queue-based scoreboard.
// Latency: checks 1-cycle ops and WIDTH+1-cycle MUL.
// Backpressure: exercises held results and same-cycle accept on release.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         z;
        logic         c;
        logic         v;
        logic         n;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic res_t mk(logic [W-1:0] hi, logic [W-1:0] lo, logic z, logic c, logic v, logic n);
        res_t r;
        r.hi = hi; r.lo = lo; r.z = z; r.c = c; r.v = v; r.n = n;
        return r;
    endfunction

    function automatic res_t observe();
        return {bus.res_hi, bus.res_lo, bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n};
    endfunction

    // Reference model written from the arithmetic definitions.
    function automatic res_t model(opcode_e op, logic [W-1:0] a, logic [W-1:0] b);
        res_t        r;
        int          t;
        int          amt;
        logic [15:0] p;
        r   = '0;
        amt = int'(b[2:0]);
        case (op)
            OP_ADD: begin
                t    = int'(a) + int'(b);
                r.lo = t[7:0];
                r.c  = (t > 255);
                r.v  = (a[7] == b[7]) && (r.lo[7] != a[7]);
            end
            OP_SUB: begin
                r.lo = a - b;
                r.c  = (a < b);
                r.v  = (a[7] != b[7]) && (r.lo[7] != a[7]);
            end
            OP_AND: r.lo = a & b;
            OP_OR:  r.lo = a | b;
            OP_XOR: r.lo = a ^ b;
            OP_SHL: begin
                p    = {8'h00, a} << amt;
                r.lo = p[7:0];
                r.c  = (amt != 0) ? a[8-amt] : 1'b0;
            end
            OP_SHR: begin
                r.lo = a >> amt;
                r.c  = (amt != 0) ? a[amt-1] : 1'b0;
            end
            default: begin
                p    = {8'h00, a} * {8'h00, b};
                r.hi = p[15:8];
                r.lo = p[7:0];
                r.c  = (r.hi != 0);
            end
        endcase
        r.z = ({r.hi, r.lo} == 16'h0000);
        r.n = (op == OP_MUL) ? r.hi[7] : r.lo[7];
        return r;
    endfunction

    // Present one op (called #1 after an edge) and return #1 after the edge that accepts it.
    task automatic send(opcode_e op, logic [W-1:0] a, logic [W-1:0] b, bit push, res_t exp);
        bit acc;
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.OPCODE   = op;
        bus.OP1      = a;
        bus.OP2      = b;
        if (push) sb.push_back(exp);
        do begin
            acc = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 100);
        bus.in_valid = 1'b0;
        checks++;
        if (acc !== 1'b1) begin
            failures++;
            $display("FAIL send_accept op=%0d got_ready=%b want=1", op, acc);
        end
    endtask

    // Wait for out_valid; lat=1 means valid right after the accepting edge.
    task automatic wait_out(output int lat);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.OPCODE    = '0;
        bus.OP1       = '0;
        bus.OP2       = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++;
        if (observe() !== res_t'(0)) begin failures++; $display("FAIL reset_outputs got=%h want=0", observe()); end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_add();
        int   lat;
        res_t exp;
        send(OP_ADD, 8'hFF, 8'h01, 1'b1, mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
        wait_out(lat);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d want=1", lat); end
        exp = sb.pop_front();
        checks++;
        if (observe() !== exp) begin failures++; $display("FAIL add_result got=%h want=%h", observe(), exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_sub();
        int   lat;
        res_t exp;
        send(OP_SUB, 8'h80, 8'h01, 1'b1, mk(8'h00, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0));
        wait_out(lat);
        exp = sb.pop_front();
        checks++;
        if (observe() !== exp) begin failures++; $display("FAIL sub_ovf got=%h want=%h", observe(), exp); end
        send(OP_SUB, 8'h01, 8'h02, 1'b1, mk(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1));
        wait_out(lat);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL sub_latency got=%0d want=1", lat); end
        exp = sb.pop_front();
        checks++;
        if (observe() !== exp) begin failures++; $display("FAIL sub_borrow got=%h want=%h", observe(), exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int   lat;
        bit   rdy_low;
        res_t exp;
        logic [W-1:0] ma[2];
        logic [W-1:0] mb[2];
        res_t me[2];
        ma[0] = 8'h0F; mb[0] = 8'h11; me[0] = mk(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        ma[1] = 8'hFF; mb[1] = 8'hFF; me[1] = mk(8'hFE, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            send(OP_MUL, ma[k], mb[k], 1'b1, me[k]);
            lat     = 1;
            rdy_low = 1'b1;
            while (bus.out_valid !== 1'b1 && lat < 100) begin
                if (bus.in_ready !== 1'b0) rdy_low = 1'b0;
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (lat !== W + 1) begin failures++; $display("FAIL mul_latency[%0d] got=%0d want=%0d", k, lat, W + 1); end
            checks++;
            if (rdy_low !== 1'b1) begin failures++; $display("FAIL mul_in_ready[%0d] got=high want=low", k); end
            exp = sb.pop_front();
            checks++;
            if (observe() !== exp) begin failures++; $display("FAIL mul_result[%0d] got=%h want=%h", k, observe(), exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        bit   stable;
        bit   rdy_low;
        res_t snap;
        res_t exp;
        bus.out_ready = 1'b0;
        send(OP_XOR, 8'h5A, 8'h3C, 1'b1, mk(8'h00, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0));
        wait_out(lat);
        exp = sb.pop_front();
        checks++;
        if (observe() !== exp) begin failures++; $display("FAIL bp_xor got=%h want=%h", observe(), exp); end
        snap    = observe();
        stable  = 1'b1;
        rdy_low = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (observe() !== snap || bus.out_valid !== 1'b1) stable = 1'b0;
            if (bus.in_ready !== 1'b0) rdy_low = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin failures++; $display("FAIL bp_hold got=%h want=%h", observe(), snap); end
        checks++;
        if (rdy_low !== 1'b1) begin failures++; $display("FAIL bp_in_ready got=high want=low"); end
        bus.in_valid  = 1'b1;
        bus.OPCODE    = OP_OR;
        bus.OP1       = 8'h0F;
        bus.OP2       = 8'hF0;
        bus.out_ready = 1'b1;
        sb.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1));
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b want=1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_same_cycle_valid got=%b want=1", bus.out_valid); end
        exp = sb.pop_front();
        checks++;
        if (observe() !== exp) begin failures++; $display("FAIL bp_or got=%h want=%h", observe(), exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        bit seen;
        send(OP_MUL, 8'h37, 8'h5B, 1'b0, res_t'(0));
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid got=%b want=0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL abort_in_ready got=%b want=1", bus.in_ready); end
        checks++;
        if (dut.state !== ST_IDLE) begin failures++; $display("FAIL abort_state got=%0d want=%0d", dut.state, ST_IDLE); end
        checks++;
        if (observe() !== res_t'(0)) begin failures++; $display("FAIL abort_outputs got=%h want=0", observe()); end
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_result got=valid want=none"); end
    endtask

    task automatic test_shift();
        int   lat;
        res_t exp;
        send(OP_SHL, 8'h81, 8'h09, 1'b1, mk(8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0));
        wait_out(lat);
        exp = sb.pop_front();
        checks++;
        if (observe() !== exp) begin failures++; $display("FAIL shl_by1 got=%h want=%h", observe(), exp); end
        send(OP_SHR, 8'h01, 8'h00, 1'b1, mk(8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0));
        wait_out(lat);
        exp = sb.pop_front();
        checks++;
        if (observe() !== exp) begin failures++; $display("FAIL shr_by0 got=%h want=%h", observe(), exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        localparam int N = 32;
        int      sent;
        int      got;
        bit      presented;
        bit      acc_prev;
        opcode_e op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        res_t    exp;
        sent      = 0;
        got       = 0;
        presented = 1'b0;
        acc_prev  = 1'b0;
        for (int cyc = 0; cyc < 3000 && got < N; cyc++) begin
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected got=%h want=none", observe());
                end else begin
                    exp = sb.pop_front();
                    if (observe() !== exp) begin failures++; $display("FAIL b2b_result[%0d] got=%h want=%h", got, observe(), exp); end
                end
                got++;
            end
            if (!presented || acc_prev) begin
                if (sent < N) begin
                    op = opcode_e'($urandom_range(0, 7));
                    a  = W'($urandom);
                    b  = W'($urandom);
                    bus.in_valid = 1'b1;
                    bus.OPCODE   = op;
                    bus.OP1      = a;
                    bus.OP2      = b;
                    sb.push_back(model(op, a, b));
                    presented = 1'b1;
                    sent++;
                end else begin
                    bus.in_valid = 1'b0;
                    presented    = 1'b0;
                end
            end
            acc_prev = presented && bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got !== N || sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_count got=%0d pending=%0d want=%0d pending=0", got, sb.size(), N);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_shift();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 4-bit combinational ALU.
- Operand width is generic; all results and flags are registered.
- Adds a multi-cycle unsigned shift-add multiplier and valid/ready flow control on both input and output.
- Sits between the operand/opcode issue logic and the writeback stage.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- SHW, $clog2(WIDTH), derived; number of OP2 LSBs used as shift amount.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  OPCODE/OP1/OP2 are valid.
- in_ready  out  1  block can accept an operation this cycle.
- OPCODE  in  3  operation select.
- OP1  in  WIDTH  first operand.
- OP2  in  WIDTH  second operand / shift amount.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer takes the result.
- res_lo  out  WIDTH  result; low half for MUL.
- res_hi  out  WIDTH  high half for MUL; 0 for all other ops.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry / borrow / shift-out flag.
- flag_v  out  1  signed overflow flag.
- flag_n  out  1  negative flag.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: out_valid=0, res_lo=0, res_hi=0, all flags 0, FSM=IDLE, in_ready=1 in the cycle after reset.
- Accept: an operation is accepted when in_valid && in_ready at a clk edge. Operands are captured at accept and ignored afterwards.
- Opcodes:
  - 000 ADD
  - 001 SUB (OP1-OP2)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL
  - 110 SHR (logical)
  - 111 MUL (unsigned)
  - All 8 codes are legal.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. Accepting a non-MUL op computes the result and goes to DONE; out_valid=1 the next cycle (latency 1). Accepting MUL loads the multiplicand, multiplier and a zeroed 2*WIDTH accumulator, sets the counter to WIDTH, and goes to MUL.
  - MUL: in_ready=0. One shift-add iteration per cycle; counter decrements. After WIDTH iterations, go to DONE; out_valid asserts exactly WIDTH+1 cycles after accept.
  - DONE: out_valid=1; outputs held stable while out_ready=0. in_ready = out_ready. On out_ready: if in_valid is also high, the new op is accepted in the same cycle (next state per its opcode). Otherwise go to IDLE and drop out_valid.
- Arithmetic: results are truncated to WIDTH (MUL gives the full 2*WIDTH).
  - ADD: C = carry-out; V = sign(OP1)==sign(OP2) && sign(res)!=sign(OP1).
  - SUB: C = borrow (OP1<OP2 unsigned); V = sign(OP1)!=sign(OP2) && sign(res)!=sign(OP1).
  - AND/OR/XOR: C=0, V=0.
  - SHL/SHR: amount = OP2[SHW-1:0]; OP2 upper bits ignored. C = last bit shifted out; C=0 if amount is 0. V=0.
  - MUL: C = (res_hi!=0); V=0.
  - Z: all result bits zero, including res_hi.
  - N: MSB of res_hi for MUL, MSB of res_lo otherwise.
- Reset mid-operation: rst in any state aborts the op. Next cycle: IDLE, out_valid=0, and no result is produced. A pending DONE result is discarded.
- rst has priority over accept in the same cycle.
- No combinational path from in_valid to out_valid. The only combinational path is out_ready to in_ready in DONE.

Decomposition:
- Package alu_pkg holds the opcode enum (OP_ADD..OP_MUL, 3 bits) and the FSM state enum.
- One sub-module, alu_mul_iter: sequential shift-add multiplier with start/busy/done and a 2*WIDTH product.
- Single-cycle ops stay in alu_seq.

Test Plan:
All cases at WIDTH=8.
1. ADD 0xFF+0x01 -> res_lo=0x00, Z=1, C=1, V=0, N=0; out_valid 1 cycle after accept.
2. SUB 0x80-0x01 -> res_lo=0x7F, V=1, C=0, N=0. Then SUB 0x01-0x02 -> 0xFF, C=1, N=1.
3. MUL 0x0F*0x11 -> res_lo=0xFF, res_hi=0x00, C=0; out_valid exactly 9 cycles after accept; in_ready=0 throughout. MUL 0xFF*0xFF -> hi=0xFE, lo=0x01, C=1.
4. Backpressure: XOR result with out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 (OR 0x0F|0xF0) -> accepted the same cycle; next cycle res_lo=0xFF.
5. rst asserted on the 4th MUL cycle -> next cycle out_valid=0, in_ready=1, FSM IDLE; no result ever appears.
6. SHL 0x81 by OP2=0x09 (amount 1) -> res_lo=0x02, C=1. SHR 0x01 by 0 -> res_lo=0x01, C=0.
